// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared fetch datapath widths, constants and buffer entry type
package instruction_fetch_unit_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0;
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pcplus4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of {instr, pcplus4}; the head reads as all zeros when empty
module fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (pop) rd <= inc(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge Clk) begin
    if (push && !flush) mem[wr] <= din;
  end
  assign dout = count == '0 ? '0 : mem[rd];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: credit-limited in-order fetch with stall hold and branch redirect/drop
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              HazardFlush,
  input  logic              Branch,
  input  logic [WORD_W-1:0] BranchTarget,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] out_Instruction,
  output logic [WORD_W-1:0] out_PCplus4,
  output logic              out_Valid
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WORD_W-1:0] pc;
  logic [CW-1:0] outstanding, drop, count, pend_count;
  logic pop, accept;
  fetch_entry_t head, pend_head;
  assign out_Valid = count != '0;
  assign pop = out_Valid & ~HazardFlush & ~Branch;
  // a slot freed by this cycle's pop may be re-issued immediately, keeping 1 instr/cycle
  assign imem_req = ~Reset & ~Branch & (int'(outstanding) + int'(count) - int'(pop) < DEPTH);
  assign imem_addr = pc;
  assign accept = imem_rvalid & ~Branch & (drop == '0);
  assign out_Instruction = head.instr;
  assign out_PCplus4 = head.pcplus4;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      pc          <= Branch ? BranchTarget : imem_req ? pc + 32'd4 : pc;
      outstanding <= outstanding + CW'(imem_req) - CW'(imem_rvalid);
      drop        <= Branch ? outstanding - CW'(imem_rvalid) : drop - CW'(imem_rvalid && drop != '0);
    end
  end
  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .Clk(Clk), .Reset(Reset), .push(accept), .pop(pop), .flush(Branch),
    .din('{instr: imem_rdata, pcplus4: pend_head.pcplus4}), .dout(head), .count(count)
  );
  fetch_buffer #(.DEPTH(DEPTH)) u_pend (
    .Clk(Clk), .Reset(Reset), .push(imem_req), .pop(imem_rvalid), .flush(1'b0),
    .din('{instr: NOP_INSTR, pcplus4: pc + 32'd4}), .dout(pend_head), .count(pend_count)
  );
  a_credit: assert property (@(posedge Clk) disable iff (Reset)
    imem_rvalid |-> (outstanding != '0 && int'(outstanding) + int'(count) <= DEPTH &&
                     pend_count == outstanding && pend_head.instr == NOP_INSTR));
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of streaming, stall, branch drop, wrap and reset
module tb_instruction_fetch_unit;
  logic Clk = 0, Reset = 0, HazardFlush = 0, Branch = 0;
  logic [31:0] BranchTarget = 0;
  logic imem_req, imem_rvalid, out_Valid;
  logic [31:0] imem_addr, imem_rdata, out_Instruction, out_PCplus4;
  int checks = 0, errors = 0, lat = 1;
  logic v1, v2;
  logic [31:0] a1, a2;

  always #5 Clk = ~Clk;

  instruction_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .Clk(Clk), .Reset(Reset), .HazardFlush(HazardFlush), .Branch(Branch),
    .BranchTarget(BranchTarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_Instruction(out_Instruction),
    .out_PCplus4(out_PCplus4), .out_Valid(out_Valid)
  );

  // memory model: in-order, latency 1 or 2, returns addr + 0x1000
  always @(posedge Clk or posedge Reset)
    if (Reset) begin
      v1 <= 0; v2 <= 0; a1 <= 0; a2 <= 0;
    end else begin
      v1 <= imem_req; a1 <= imem_addr; v2 <= v1; a2 <= a1;
    end
  assign imem_rvalid = lat == 1 ? v1 : v2;
  assign imem_rdata = (lat == 1 ? a1 : a2) + 32'h1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
    check({tag, ".valid"}, {31'b0, out_Valid}, {31'b0, v});
    check({tag, ".instr"}, out_Instruction, ins);
    check({tag, ".pc4"}, out_PCplus4, p4);
  endtask

  task automatic step;
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    Reset = 1; lat = l; Branch = 0; HazardFlush = 0;
    repeat (2) @(negedge Clk);
    Reset = 0;
    #1;
  endtask

  initial begin
    #2 Reset = 1;
    #1;
    check_out("reset", 0, 0, 0);
    check("reset.req", {31'b0, imem_req}, 0);
    check("reset.addr", imem_addr, 0);
    // stream with latency 1
    do_reset(1);
    check("s0.req", {31'b0, imem_req}, 1);
    check("s0.addr", imem_addr, 0);
    step; check("s1.addr", imem_addr, 4); check("s1.valid", {31'b0, out_Valid}, 0);
    step; check_out("s2", 1, 32'h1000, 4); check("s2.addr", imem_addr, 8);
    step; check_out("s3", 1, 32'h1004, 8);
    step; check_out("s4", 1, 32'h1008, 12);
    // stall for 3 cycles
    HazardFlush = 1; #1;
    check("h4.req", {31'b0, imem_req}, 0);
    step; check_out("h5", 1, 32'h1008, 12); check("h5.req", {31'b0, imem_req}, 0);
    step; check_out("h6", 1, 32'h1008, 12); check("h6.req", {31'b0, imem_req}, 0);
    step; check_out("h7", 1, 32'h1008, 12);
    HazardFlush = 0; #1;
    check("h7.req", {31'b0, imem_req}, 1); check("h7.addr", imem_addr, 16);
    step; check_out("h8", 1, 32'h100c, 16);
    step; check_out("h9", 1, 32'h1010, 20);
    step; check_out("h10", 1, 32'h1014, 24);
    // branch with two requests in flight, latency 2
    do_reset(2);
    step; check("b1.addr", imem_addr, 4); check("b1.req", {31'b0, imem_req}, 1);
    step; check("b2.req", {31'b0, imem_req}, 0); check("b2.rvalid", {31'b0, imem_rvalid}, 1);
    Branch = 1; BranchTarget = 32'h400;
    step; Branch = 0; #1;
    check("b3.addr", imem_addr, 32'h400); check("b3.req", {31'b0, imem_req}, 1);
    check("b3.valid", {31'b0, out_Valid}, 0);
    step; check("b4.valid", {31'b0, out_Valid}, 0); check("b4.addr", imem_addr, 32'h404);
    step; check("b5.valid", {31'b0, out_Valid}, 0);
    step; check_out("b6", 1, 32'h1400, 32'h404);
    // branch + stall + arriving response, latency 1
    do_reset(1);
    step; step;
    check_out("c2", 1, 32'h1000, 4); check("c2.rvalid", {31'b0, imem_rvalid}, 1);
    Branch = 1; HazardFlush = 1; BranchTarget = 32'h800; #1;
    check("c2.req", {31'b0, imem_req}, 0);
    step; Branch = 0; HazardFlush = 0; #1;
    check("c3.valid", {31'b0, out_Valid}, 0); check("c3.addr", imem_addr, 32'h800);
    step; check("c4.valid", {31'b0, out_Valid}, 0);
    step; check_out("c5", 1, 32'h1800, 32'h804);
    // PC wrap
    Branch = 1; BranchTarget = 32'hFFFF_FFFC;
    step; Branch = 0; #1;
    check("w6.addr", imem_addr, 32'hFFFF_FFFC);
    step; check("w7.addr", imem_addr, 0); check("w7.valid", {31'b0, out_Valid}, 0);
    step; check_out("w8", 1, 32'h0000_0FFC, 0);
    step; check_out("w9", 1, 32'h1000, 4);
    // fill buffer, then asynchronous reset mid-cycle
    HazardFlush = 1;
    step; check("r10.req", {31'b0, imem_req}, 0);
    step; check_out("r11", 1, 32'h1000, 4);
    #2 Reset = 1; #1;
    check_out("r_async", 0, 0, 0);
    check("r_async.req", {31'b0, imem_req}, 0);
    check("r_async.addr", imem_addr, 0);
    @(negedge Clk); Reset = 0; HazardFlush = 0; #1;
    check("r0.req", {31'b0, imem_req}, 1); check("r0.addr", imem_addr, 0);
    step; step; check_out("r2", 1, 32'h1000, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
